cond_unit: RTL and testbench



---
 rtl/cond_unit_pkg.sv | 48 ++++
 rtl/cond_unit_if.sv | 52 +++++
 rtl/cond_unit_cond_check.sv | 34 +++
 rtl/cond_unit.sv | 71 +++++++
 tb/tb_cond_unit.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/cond_unit_pkg.sv
// cond_unit_pkg: shared ARM condition codes, ALU opcodes, flag indices and opcode class helper
package cond_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Arithmetic opcodes take C and V from the adder; the rest are logical
  function automatic logic is_arith(input logic [3:0] op);
    return op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN};
  endfunction

endpackage

// File: rtl/cond_unit_if.sv
// cond_unit_if: decoder/ALU-side signal bundle for cond_unit (perf counters under COND_PERF_CNT_EN)
interface cond_unit_if
`ifdef COND_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  logic       En;
  logic [3:0] Cond;
  logic       DPOp;
  logic [3:0] ALUOpCode;
  logic       SBit;
  logic       NFlagIn;
  logic       ZFlagIn;
  logic       CFlagIn;
  logic       VFlagIn;
  logic       ShifterCarry;
  logic       RegWriteReq;
  logic       MemWriteReq;
  logic       PCSrcReq;
  logic       RegWrite;
  logic       MemWrite;
  logic       PCSrc;
  logic       CondEx;
  logic [3:0] Flags;
  logic       CarryIn;
`ifdef COND_PERF_CNT_EN
  logic             CntClr;
  logic [CNT_W-1:0] ExecCount;
  logic [CNT_W-1:0] SkipCount;
`endif

  modport slave (
    input  En, Cond, DPOp, ALUOpCode, SBit, NFlagIn, ZFlagIn, CFlagIn, VFlagIn,
           ShifterCarry, RegWriteReq, MemWriteReq, PCSrcReq,
`ifdef COND_PERF_CNT_EN
    input  CntClr,
    output ExecCount, SkipCount,
`endif
    output RegWrite, MemWrite, PCSrc, CondEx, Flags, CarryIn
  );

  modport master (
    output En, Cond, DPOp, ALUOpCode, SBit, NFlagIn, ZFlagIn, CFlagIn, VFlagIn,
           ShifterCarry, RegWriteReq, MemWriteReq, PCSrcReq,
`ifdef COND_PERF_CNT_EN
    output CntClr,
    input  ExecCount, SkipCount,
`endif
    input  RegWrite, MemWrite, PCSrc, CondEx, Flags, CarryIn
  );

endinterface

// File: rtl/cond_unit_cond_check.sv
// cond_check: evaluates a 4-bit ARM condition field against {N,Z,C,V}
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];
  // pass/fail per condition; AL and the unconditional space both pass
  always_comb begin
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c & !z;
      COND_LS: cond_ex = !c | z;
      COND_GE: cond_ex = n == v;
      COND_LT: cond_ex = n != v;
      COND_GT: cond_ex = !z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      default: cond_ex = 1'b1;
    endcase
  end
endmodule

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, condition evaluation and request gating
// (COND_PERF_CNT_EN adds executed/skipped instruction counters)
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
`ifdef COND_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        CLK,
  input  logic        nRESET,
  cond_unit_if.slave  bus
);
  logic [3:0] flags_q, flags_d;
  logic       cond_ex;
  logic       flag_write;

  cond_check u_check (
    .cond    (bus.Cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  assign flag_write = bus.En & bus.DPOp & bus.SBit & cond_ex;

  // next flags: arithmetic takes all four from the ALU, logical takes C from the shifter and keeps V
  always_comb begin
    flags_d = !flag_write ? flags_q :
              is_arith(bus.ALUOpCode) ? {bus.NFlagIn, bus.ZFlagIn, bus.CFlagIn, bus.VFlagIn} :
              {bus.NFlagIn, bus.ZFlagIn, bus.ShifterCarry, flags_q[FLAG_V]};
  end

  // flag register with asynchronous clear
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) flags_q <= FLAG_RESET;
    else         flags_q <= flags_d;
  end

  assign bus.CondEx   = cond_ex;
  assign bus.RegWrite = bus.RegWriteReq & cond_ex;
  assign bus.MemWrite = bus.MemWriteReq & cond_ex;
  assign bus.PCSrc    = bus.PCSrcReq & cond_ex;
  assign bus.Flags    = flags_q;
  assign bus.CarryIn  = flags_q[FLAG_C];

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] exec_q, exec_d, skip_q, skip_d;

  // saturating counters; clear wins over increment
  always_comb begin
    exec_d = bus.CntClr ? '0 : (bus.En & cond_ex & ~&exec_q) ? exec_q + 1'b1 : exec_q;
    skip_d = bus.CntClr ? '0 : (bus.En & !cond_ex & ~&skip_q) ? skip_q + 1'b1 : skip_q;
  end

  // counter registers with asynchronous clear
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      exec_q <= '0;
      skip_q <= '0;
    end else begin
      exec_q <= exec_d;
      skip_q <= skip_d;
    end
  end

  assign bus.ExecCount = exec_q;
  assign bus.SkipCount = skip_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed stimulus with a behavioural flag/condition model and per-cycle compare
module tb_cond_unit;
  import cond_unit_pkg::*;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int checks = 0;
  int errors = 0;

  cond_unit_if bus();
  cond_unit dut (.CLK(clk), .nRESET(nreset), .bus(bus));

  always #5 clk = ~clk;

  logic mn = 1'b0, mz = 1'b0, mc = 1'b0, mv = 1'b0;
`ifdef COND_PERF_CNT_EN
  longint m_exec = 0, m_skip = 0;
`endif

  // Even condition codes name a test, the odd neighbour is its inverse; 14/15 always pass
  function automatic logic passes(input logic [3:0] c, input logic n, input logic z,
                                  input logic cy, input logic v);
    logic base;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] == 3'd7) ? 1'b1 : (base ^ c[0]);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model state update at the clock edge
  always @(posedge clk) begin
    logic pe;
    if (nreset) begin
      pe = passes(bus.Cond, mn, mz, mc, mv);
`ifdef COND_PERF_CNT_EN
      if (bus.CntClr) begin
        m_exec = 0;
        m_skip = 0;
      end else if (bus.En) begin
        if (pe) m_exec = m_exec + 1;
        else    m_skip = m_skip + 1;
      end
`endif
      if (bus.En && bus.DPOp && bus.SBit && pe) begin
        mn = bus.NFlagIn;
        mz = bus.ZFlagIn;
        if (bus.ALUOpCode inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11}) begin
          mc = bus.CFlagIn;
          mv = bus.VFlagIn;
        end else begin
          mc = bus.ShifterCarry;
        end
      end
    end
  end

  always @(negedge nreset) begin
    {mn, mz, mc, mv} = 4'b0000;
`ifdef COND_PERF_CNT_EN
    m_exec = 0;
    m_skip = 0;
`endif
  end

  // per-cycle compare of every output against the model
  always @(negedge clk) begin
    logic ce;
    ce = passes(bus.Cond, mn, mz, mc, mv);
    chk("Flags", 64'(bus.Flags), 64'({mn, mz, mc, mv}));
    chk("CondEx", 64'(bus.CondEx), 64'(ce));
    chk("RegWrite", 64'(bus.RegWrite), 64'(bus.RegWriteReq & ce));
    chk("MemWrite", 64'(bus.MemWrite), 64'(bus.MemWriteReq & ce));
    chk("PCSrc", 64'(bus.PCSrc), 64'(bus.PCSrcReq & ce));
    chk("CarryIn", 64'(bus.CarryIn), 64'(mc));
`ifdef COND_PERF_CNT_EN
    chk("ExecCount", 64'(bus.ExecCount), 64'(m_exec));
    chk("SkipCount", 64'(bus.SkipCount), 64'(m_skip));
`endif
  end

  task automatic idle();
    bus.En = 1'b0;
    bus.DPOp = 1'b0;
    bus.SBit = 1'b0;
    bus.ALUOpCode = OP_MOV;
    {bus.NFlagIn, bus.ZFlagIn, bus.CFlagIn, bus.VFlagIn} = 4'b0000;
    bus.ShifterCarry = 1'b0;
    {bus.RegWriteReq, bus.MemWriteReq, bus.PCSrcReq} = 3'b000;
  endtask

  task automatic drive(input logic [3:0] c, input logic en, input logic dp, input logic [3:0] op,
                       input logic s, input logic [3:0] nzcv, input logic sc, input logic [2:0] rq);
    bus.Cond = c;
    bus.En = en;
    bus.DPOp = dp;
    bus.ALUOpCode = op;
    bus.SBit = s;
    {bus.NFlagIn, bus.ZFlagIn, bus.CFlagIn, bus.VFlagIn} = nzcv;
    bus.ShifterCarry = sc;
    {bus.RegWriteReq, bus.MemWriteReq, bus.PCSrcReq} = rq;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic cond_at(input string nm, input logic [3:0] c, input logic exp);
    bus.Cond = c;
    #1;
    chk(nm, 64'(bus.CondEx), 64'(exp));
  endtask

  initial begin
    idle();
    bus.Cond = COND_AL;
`ifdef COND_PERF_CNT_EN
    bus.CntClr = 1'b0;
`endif
    #1;
    chk("reset_flags", 64'(bus.Flags), 64'h0);
    cond_at("reset_eq", COND_EQ, 1'b0);
    cond_at("reset_ne", COND_NE, 1'b1);
    cond_at("reset_al", COND_AL, 1'b1);
    @(posedge clk);
    #1;
    nreset = 1'b1;

    drive(COND_AL, 1, 1, OP_CMP, 1, 4'b0110, 0, 3'b000); tick();
    chk("cmp_flags", 64'(bus.Flags), 64'b0110);
    cond_at("cmp_eq", COND_EQ, 1'b1);
    cond_at("cmp_hi", COND_HI, 1'b0);

    drive(COND_AL, 1, 1, OP_ADD, 1, 4'b1011, 0, 3'b111); tick();
    chk("add_flags", 64'(bus.Flags), 64'b1011);
    drive(COND_AL, 1, 1, OP_AND, 1, 4'b0100, 0, 3'b101); tick();
    chk("and_flags", 64'(bus.Flags), 64'b0101);
    drive(COND_AL, 1, 1, OP_MOV, 1, 4'b1000, 1, 3'b010); tick();
    chk("mov_flags", 64'(bus.Flags), 64'b1011);

    drive(COND_AL, 1, 1, OP_SUB, 1, 4'b0000, 0, 3'b000); tick();
    drive(COND_EQ, 1, 1, OP_ADD, 1, 4'b1111, 1, 3'b111);
    #1;
    chk("supp_regwrite", 64'(bus.RegWrite), 64'h0);
    chk("supp_memwrite", 64'(bus.MemWrite), 64'h0);
    chk("supp_pcsrc", 64'(bus.PCSrc), 64'h0);
    tick();
    chk("supp_flags", 64'(bus.Flags), 64'h0);

    drive(COND_AL, 1, 1, OP_ADD, 1, 4'b1001, 0, 3'b000); tick();
    cond_at("s1001_ge", COND_GE, 1'b1);
    cond_at("s1001_lt", COND_LT, 1'b0);
    cond_at("s1001_gt", COND_GT, 1'b1);
    cond_at("s1001_le", COND_LE, 1'b0);
    drive(COND_AL, 1, 1, OP_SUB, 1, 4'b1000, 0, 3'b000); tick();
    cond_at("s1000_ge", COND_GE, 1'b0);
    cond_at("s1000_lt", COND_LT, 1'b1);
    cond_at("s1000_le", COND_LE, 1'b1);

    drive(COND_AL, 1, 1, OP_CMP, 0, 4'b0111, 1, 3'b000); tick();
    chk("nos_flags", 64'(bus.Flags), 64'b1000);
    drive(COND_AL, 0, 1, OP_ADD, 1, 4'b0111, 1, 3'b111); tick();
    chk("en0_flags", 64'(bus.Flags), 64'b1000);
    drive(COND_MI, 1, 1, OP_RSB, 1, 4'b0011, 0, 3'b110); tick();
    drive(COND_CS, 1, 1, OP_EOR, 1, 4'b1100, 0, 3'b011); tick();
    drive(COND_VC, 1, 0, OP_ADD, 1, 4'b1111, 1, 3'b111); tick();

    drive(COND_AL, 1, 1, OP_ADD, 1, 4'b1111, 1, 3'b000); tick();
    chk("pre_async_flags", 64'(bus.Flags), 64'b1111);
    #2;
    nreset = 1'b0;
    #1;
    chk("async_flags", 64'(bus.Flags), 64'h0);
    chk("async_carry", 64'(bus.CarryIn), 64'h0);
    @(posedge clk);
    #1;
    nreset = 1'b1;

`ifdef COND_PERF_CNT_EN
    for (int i = 0; i < 3; i++) begin
      drive(COND_AL, 1, 0, OP_MOV, 0, 4'b0000, 0, 3'b000); tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(COND_EQ, 1, 0, OP_MOV, 0, 4'b0000, 0, 3'b000); tick();
    end
    chk("exec_count", 64'(bus.ExecCount), 64'd3);
    chk("skip_count", 64'(bus.SkipCount), 64'd2);
    drive(COND_AL, 1, 0, OP_MOV, 0, 4'b0000, 0, 3'b000);
    bus.CntClr = 1'b1;
    tick();
    bus.CntClr = 1'b0;
    chk("clr_exec", 64'(bus.ExecCount), 64'd0);
    chk("clr_skip", 64'(bus.SkipCount), 64'd0);
`endif

    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
